// File: rtl/bcd_splitter_seq.sv
// Iterative binary-to-packed-BCD converter (double-dabble, one input bit per clock).
// Optional leading-zero blanking output enabled by defining BCD_SPLITTER_SEQ_BLANK_EN.
module bcd_splitter_seq #(
    parameter int unsigned IN_WIDTH = 6,
    parameter int unsigned DIGITS   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [IN_WIDTH-1:0]   value_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  overflow_o
`ifdef BCD_SPLITTER_SEQ_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank_o
`endif
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(IN_WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StShift, StFinish} state_e;

    state_e              state_q, state_d;
    logic [IN_WIDTH-1:0] shift_q, shift_d;
    logic [BcdW-1:0]     scratch_q, scratch_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [BcdW-1:0]     bcd_q, bcd_d;
    logic                overflow_q, overflow_d;
    logic                done_q, done_d;

    logic [BcdW-1:0]     adj;
    logic [BcdW-1:0]     scratch_sh;
    logic [IN_WIDTH-1:0] shift_sh;
    logic                carry_out;
    logic [BcdW-1:0]     all_nines;

    // Add-3 correction happens before the shift within the same cycle.
    always_comb begin
        adj       = '0;
        all_nines = '0;
        for (int k = 0; k < DIGITS; k++) begin
            adj[4*k +: 4]       = scratch_q[4*k +: 4] +
                                  ((scratch_q[4*k +: 4] >= 4'd5) ? 4'd3 : 4'd0);
            all_nines[4*k +: 4] = 4'h9;
        end
        {carry_out, scratch_sh, shift_sh} = {adj, shift_q, 1'b0};
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    shift_d   = value_i;
                    scratch_d = '0;
                    cnt_d     = CntW'(IN_WIDTH);
                    ovf_d     = 1'b0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                scratch_d = scratch_sh;
                shift_d   = shift_sh;
                ovf_d     = ovf_q | carry_out;
                cnt_d     = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                bcd_d      = ovf_q ? all_nines : scratch_q;
                overflow_d = ovf_q;
                done_d     = 1'b1;
                state_d    = StIdle;
                // Back-to-back conversions: a start here is accepted like in idle.
                if (start_i) begin
                    shift_d   = value_i;
                    scratch_d = '0;
                    cnt_d     = CntW'(IN_WIDTH);
                    ovf_d     = 1'b0;
                    state_d   = StShift;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign busy_o     = (state_q == StShift);
    assign done_o     = done_q;
    assign bcd_o      = bcd_q;
    assign overflow_o = overflow_q;

`ifdef BCD_SPLITTER_SEQ_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic [DIGITS-1:0] blank_n;
    logic              hi_zero;

    // Digit k blanks only when it and every digit above it are zero; units never blank.
    always_comb begin
        blank_n = '0;
        hi_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            hi_zero    = hi_zero & (scratch_q[4*k +: 4] == 4'd0);
            blank_n[k] = hi_zero & ~ovf_q;
        end
    end

    always_comb begin
        blank_d = blank_q;
        if (state_q == StFinish) begin
            blank_d = blank_n;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank_o = blank_q;
`endif

endmodule

// File: tb/tb_bcd_splitter_seq.sv
// Scoreboard bench for bcd_splitter_seq: three instances (6,2), (7,2) and (10,4).
module tb_bcd_splitter_seq;

    localparam int unsigned WA = 6;
    localparam int unsigned WB = 7;
    localparam int unsigned WC = 10;
`ifdef BCD_SPLITTER_SEQ_BLANK_EN
    localparam bit BlankEn = 1'b1;
`else
    localparam bit BlankEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          start_a, busy_a, done_a, ovf_a;
    logic [WA-1:0] value_a;
    logic [7:0]    bcd_a;
    logic          start_b, busy_b, done_b, ovf_b;
    logic [WB-1:0] value_b;
    logic [7:0]    bcd_b;
    logic          start_c, busy_c, done_c, ovf_c;
    logic [WC-1:0] value_c;
    logic [15:0]   bcd_c;
    logic [3:0]    blank_c;

    logic [63:0] q_a[$];
    logic [63:0] q_b[$];
    logic [63:0] q_c[$];

    int n_checks = 0;
    int n_errors = 0;

    bcd_splitter_seq #(.IN_WIDTH(WA), .DIGITS(2)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .value_i(value_a),
        .busy_o(busy_a), .done_o(done_a), .bcd_o(bcd_a), .overflow_o(ovf_a)
    );

    bcd_splitter_seq #(.IN_WIDTH(WB), .DIGITS(2)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .value_i(value_b),
        .busy_o(busy_b), .done_o(done_b), .bcd_o(bcd_b), .overflow_o(ovf_b)
    );

`ifdef BCD_SPLITTER_SEQ_BLANK_EN
    bcd_splitter_seq #(.IN_WIDTH(WC), .DIGITS(4)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_c), .value_i(value_c),
        .busy_o(busy_c), .done_o(done_c), .bcd_o(bcd_c), .overflow_o(ovf_c),
        .blank_o(blank_c)
    );
`else
    bcd_splitter_seq #(.IN_WIDTH(WC), .DIGITS(4)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_c), .value_i(value_c),
        .busy_o(busy_c), .done_o(done_c), .bcd_o(bcd_c), .overflow_o(ovf_c)
    );
    assign blank_c = 4'b0000;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Layout: bcd in [23:0], overflow at bit 24, blank from bit 25 upward.
    function automatic logic [63:0] model(input int unsigned v, input int unsigned digits,
                                          input bit with_blank);
        logic [63:0] r;
        int unsigned lim, t, p;
        r   = '0;
        lim = 1;
        for (int k = 0; k < digits; k++) lim = lim * 10;
        if (v >= lim) begin
            for (int k = 0; k < digits; k++) r[4*k +: 4] = 4'h9;
            r[24] = 1'b1;
        end else begin
            t = v;
            for (int k = 0; k < digits; k++) begin
                r[4*k +: 4] = 4'(t % 10);
                t = t / 10;
            end
            if (with_blank) begin
                p = 10;
                for (int k = 1; k < digits; k++) begin
                    r[25+k] = ((v / p) == 0);
                    p = p * 10;
                end
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done_a) begin
            if (q_a.size() == 0) check("a_extra_done", 64'(done_a), 64'd0);
            else check("a_result", {39'd0, ovf_a, 16'd0, bcd_a}, q_a.pop_front());
        end
        if (rst_n && done_b) begin
            if (q_b.size() == 0) check("b_extra_done", 64'(done_b), 64'd0);
            else check("b_result", {39'd0, ovf_b, 16'd0, bcd_b}, q_b.pop_front());
        end
        if (rst_n && done_c) begin
            if (q_c.size() == 0) check("c_extra_done", 64'(done_c), 64'd0);
            else check("c_result", {35'd0, blank_c, ovf_c, 8'd0, bcd_c}, q_c.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int busy_cnt;
    int done_at;
    int unsigned vals_b[3] = '{99, 100, 127};
    int unsigned vals_c[5] = '{7, 0, 305, 1023, 1000};

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0; value_a = '0;
        start_b = 1'b0; value_b = '0;
        start_c = 1'b0; value_c = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bcd_a", 64'(bcd_a), 64'd0);
        check("rst_ovf_a", 64'(ovf_a), 64'd0);
        check("rst_busy_a", 64'(busy_a), 64'd0);
        check("rst_done_a", 64'(done_a), 64'd0);
        check("rst_bcd_c", 64'(bcd_c), 64'd0);
        check("rst_blank_c", 64'(blank_c), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single conversion with latency and busy-length measurement.
        value_a = 6'd59; start_a = 1'b1; q_a.push_back(model(59, 2, 1'b0));
        tick();
        start_a = 1'b0;
        check("t1_busy_e0", 64'(busy_a), 64'd1);
        busy_cnt = 1;
        done_at  = 0;
        for (int i = 1; i <= int'(WA) + 3; i++) begin
            tick();
            if (busy_a) busy_cnt++;
            if (done_a && done_at == 0) done_at = i;
        end
        check("t1_latency", 64'(done_at), 64'(WA + 1));
        check("t1_busy_len", 64'(busy_cnt), 64'(WA));
        check("t1_bcd", 64'(bcd_a), 64'h59);

        // Back-to-back sweep, each start landing in the finish cycle.
        for (int v = 0; v <= 59; v++) begin
            value_a = 6'(v); start_a = 1'b1; q_a.push_back(model(v, 2, 1'b0));
            tick();
            start_a = 1'b0;
            value_a = 6'($urandom);
            repeat (WA) tick();
            check("sweep_finish_idle", 64'(busy_a), 64'd0);
        end
        repeat (3) tick();

        // Start while busy is ignored.
        value_a = 6'd42; start_a = 1'b1; q_a.push_back(model(42, 2, 1'b0));
        tick();
        start_a = 1'b0;
        tick();
        tick();
        value_a = 6'd13; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (WA + 3) tick();
        check("ignore_bcd", 64'(bcd_a), 64'h42);

        // Reset in the middle of a conversion abandons it.
        value_a = 6'd37; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_bcd", 64'(bcd_a), 64'd0);
        check("mid_rst_busy", 64'(busy_a), 64'd0);
        check("mid_rst_done", 64'(done_a), 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (WA + 3) tick();
        value_a = 6'd8; start_a = 1'b1; q_a.push_back(model(8, 2, 1'b0));
        tick();
        start_a = 1'b0;
        repeat (WA + 2) tick();
        check("post_rst_bcd", 64'(bcd_a), 64'h08);

        // Maximum input value for the default instance.
        value_a = 6'd63; start_a = 1'b1; q_a.push_back(model(63, 2, 1'b0));
        tick();
        start_a = 1'b0;
        repeat (WA + 2) tick();

        // Overflow boundary for the 7-bit instance.
        foreach (vals_b[i]) begin
            value_b = 7'(vals_b[i]); start_b = 1'b1; q_b.push_back(model(vals_b[i], 2, 1'b0));
            tick();
            start_b = 1'b0;
            repeat (WB + 2) tick();
        end
        check("b_last_ovf", 64'(ovf_b), 64'd1);

        // Four-digit instance, including blanking when enabled.
        foreach (vals_c[i]) begin
            value_c = 10'(vals_c[i]); start_c = 1'b1;
            q_c.push_back(model(vals_c[i], 4, BlankEn));
            tick();
            start_c = 1'b0;
            repeat (WC + 2) tick();
        end

        check("a_pending", 64'(q_a.size()), 64'd0);
        check("b_pending", 64'(q_b.size()), 64'd0);
        check("c_pending", 64'(q_c.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
